// File: rtl/ti_adc_pkg.sv
// ti_adc_pkg: shared state encodings, defaults and helpers for the TI-ADC calibration logic
package ti_adc_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CAL = 2'd1, GAP = 2'd2} state_t;
  localparam int ADC_WAYS_DEF = 8;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/ti_rr_arbiter.sv
// ti_rr_arbiter: combinational round-robin picker, first request strictly after ptr
module ti_rr_arbiter #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);
  // scan from farthest to nearest so the nearest requester after ptr wins
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = N; i >= 1; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        gnt = '0;
        gnt[(int'(ptr) + i) % N] = 1'b1;
        idx = W'((int'(ptr) + i) % N);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ti_cal_scheduler.sv
// ti_cal_scheduler: frame-aligned round-robin background calibration scheduler for a TI SAR-ADC
module ti_cal_scheduler import ti_adc_pkg::*; #(
  parameter int ADC_WAYS = ADC_WAYS_DEF,
  parameter int CLK_INIT = 0,
  parameter int CAL_LEN  = 16,
  parameter int GAP_LEN  = 2,
  parameter int IDX_W    = clog2(ADC_WAYS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [ADC_WAYS-1:0] cal_req,
  output logic [IDX_W-1:0]    slot,
  output logic [ADC_WAYS-1:0] cal_gnt,
  output logic [IDX_W-1:0]    cal_way,
  output logic                cal_busy,
  output logic [ADC_WAYS-1:0] way_valid,
  output logic                cal_done,
  output logic                cal_abort
);
  localparam int CNT_W = clog2(CAL_LEN > GAP_LEN ? CAL_LEN : GAP_LEN) + 1;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [IDX_W-1:0] ptr, ptr_n, way_n, pick_idx;
  logic [ADC_WAYS-1:0] gnt_q, gnt_n, pick_gnt;
  logic done_n, abort_n, pick_any, fb, arb;
  assign fb = slot == IDX_W'(ADC_WAYS - 1);
  assign cal_busy = state == CAL;
  assign cal_gnt = cal_busy ? gnt_q : '0;
  assign way_valid = ~cal_gnt;
  ti_rr_arbiter #(.N(ADC_WAYS), .W(IDX_W)) u_arb (
    .req(cal_req),
    .ptr(ptr),
    .gnt(pick_gnt),
    .idx(pick_idx),
    .any(pick_any)
  );
  // state register and slot counter tracking the TI clock rotation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot      <= IDX_W'(CLK_INIT);
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= IDX_W'(ADC_WAYS - 1);
      cal_way   <= '0;
      gnt_q     <= '0;
      cal_done  <= 1'b0;
      cal_abort <= 1'b0;
    end else begin
      slot      <= fb ? '0 : slot + 1'b1;
      state     <= state_n;
      cnt       <= cnt_n;
      ptr       <= ptr_n;
      cal_way   <= way_n;
      gnt_q     <= gnt_n;
      cal_done  <= done_n;
      cal_abort <= abort_n;
    end
  end
  // next-state logic, evaluated only on frame boundaries
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ptr_n   = ptr;
    way_n   = cal_way;
    gnt_n   = gnt_q;
    done_n  = 1'b0;
    abort_n = 1'b0;
    arb     = 1'b0;
    if (fb) begin
      case (state)
        IDLE: arb = 1'b1;
        CAL: begin
          abort_n = !en || !cal_req[cal_way];
          done_n  = !abort_n && cnt == CNT_W'(CAL_LEN - 1);
          if (abort_n || done_n) begin
            state_n = (GAP_LEN == 0) ? IDLE : GAP;
            cnt_n   = '0;
          end else cnt_n = cnt + 1'b1;
        end
        GAP: begin
          if (cnt == CNT_W'(GAP_LEN - 1)) begin
            state_n = IDLE;
            arb     = 1'b1;
          end else cnt_n = cnt + 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
    if (arb && en && pick_any) begin
      state_n = CAL;
      cnt_n   = '0;
      ptr_n   = pick_idx;
      way_n   = pick_idx;
      gnt_n   = pick_gnt;
    end
  end
endmodule

// File: doc/ti_cal_scheduler.md
Name: ti_cal_scheduler

Overview:
Background-calibration scheduler for the time-interleaved SAR-ADC. It tracks which interleaved way is sampling, in lock-step with the one-hot TI clock rotation. It round-robin arbitrates calibration requests from the ADC ways and takes exactly one way offline at a time, for a fixed number of interleave frames. Grant changes are frame-aligned, so the back-end combiner can substitute the missing way cleanly. It sits beside the TI clock generator on the same fast clock and drives the per-way calibration engines and the output combiner.

Parameters:
ADC_WAYS, 8, number of interleaved ways (>=2).
CLK_INIT, 0, way index sampling out of reset; must match the TI clock generator's reset way.
CAL_LEN, 16, frames (ADC_WAYS cycles each) a granted way stays offline (>=1).
GAP_LEN, 2, idle frames forced after every calibration, completed or aborted (>=0).
IDX_W, 3, index width, = clog2(ADC_WAYS).

Ports:
clk  in  1  fast interleave clock, same edge as the TI clock generator.
rst  in  1  asynchronous, active-low reset.
en  in  1  scheduler enable.
cal_req  in  ADC_WAYS  per-way calibration request; level, held until granted and through calibration.
slot  out  IDX_W  index of the way currently sampling.
cal_gnt  out  ADC_WAYS  one-hot grant; all-zero when no way is offline.
cal_way  out  IDX_W  binary index of the granted way; valid while cal_busy.
cal_busy  out  1  high while in CAL.
way_valid  out  ADC_WAYS  equals ~cal_gnt; tells the combiner which ways carry valid data.
cal_done  out  1  one-cycle pulse on normal completion.
cal_abort  out  1  one-cycle pulse on early termination.

Behaviour:
Reset values (asynchronous):
- slot=CLK_INIT, cal_gnt=0, cal_way=0, cal_busy=0, way_valid=all ones, cal_done=0, cal_abort=0.
- State IDLE; rr pointer=ADC_WAYS-1, so way 0 has first priority.

Slot counter and frame boundary:
- slot increments every clk, wrapping ADC_WAYS-1 -> 0.
- A frame boundary (fb) is any cycle with slot==ADC_WAYS-1.
- All state changes of the FSM take effect on the edge leaving a boundary cycle, i.e. the cycle in which slot becomes 0.

FSM states: IDLE, CAL, GAP.
- IDLE:
  - At fb with en=1 and any cal_req set, pick the first requesting way strictly after the rr pointer, wrapping.
  - Next cycle: CAL, cal_gnt/cal_way/cal_busy asserted, frame count=0, rr pointer=picked way.
  - Requests sampled only at fb; a request raised and dropped between boundaries is ignored.
- CAL, evaluated at each fb, in priority order:
  - If en=0 or cal_req[cal_way]=0: abort.
  - Else if frame count==CAL_LEN-1: complete.
  - Else increment frame count.
  - Abort and complete both release cal_gnt in the next cycle. They pulse cal_abort or cal_done respectively in that same cycle, then go to GAP (or IDLE if GAP_LEN==0).
  - A normal calibration therefore holds grant for exactly CAL_LEN*ADC_WAYS cycles.
- GAP:
  - Count GAP_LEN frames at fb, then IDLE.
  - Requests are ignored during GAP.
  - The first new grant can appear at the fb ending the last gap frame, so IDLE is entered and arbitration happens at that same boundary (no lost frame).
- en=0 in IDLE or GAP: no new grants; the GAP count still runs.

Boundary conditions:
- Requests from other ways during CAL are held pending, never pre-empt.
- Simultaneous requests resolve round-robin.
- CLK_INIT=ADC_WAYS-1 makes cycle 0 after reset a boundary.
- cal_done and cal_abort are mutually exclusive.
- Reset mid-CAL clears grant immediately, with no pulse.

Decomposition:
- Shared header/package ti_adc_pkg:
  - state encodings IDLE=0, CAL=1, GAP=2;
  - default ADC_WAYS;
  - clog2 function for IDX_W.
- One sub-module, ti_rr_arbiter: combinational round-robin picker.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, index, any.
  - Instantiated once.

Test Plan (ADC_WAYS=8, CAL_LEN=4, GAP_LEN=2, CLK_INIT=0):
1. Reset release, en=1, no requests -> slot counts 0..7 repeatedly; cal_gnt=0, way_valid=8'hFF for 100 cycles.
2. cal_req[3] raised while slot=2 and held -> cal_gnt=8'h08, cal_way=3, way_valid=8'hF7 from the next slot=0 for exactly 32 cycles. cal_done pulses when grant drops; no grant for the following 16 cycles.
3. cal_req[1] and cal_req[5] raised together and held -> grants in order 1, 5, 1, 5. Each grant lasts 32 cycles with 16-cycle gaps between grants.
4. cal_req[3] dropped during frame 2 of CAL -> at the next slot=0, cal_gnt=0 and cal_abort pulses (cal_done stays 0); a 16-cycle gap follows.
5. en=0 with cal_req=8'hFF -> no grant. Raise en -> way 0 granted at the next slot=0. Drop en mid-CAL -> abort at the next boundary.
6. rst asserted mid-CAL at slot=5 -> cal_gnt=0, way_valid=8'hFF, slot=0 immediately. After release, the sequence restarts with way 0 priority.
